wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Write-back stage directly upstream of the 32x64 register file. Merges two
//  result streams into the file's single write port (REG_WRITE/WR_REG/WR_DATA):
//  - single-cycle ALU results, which have priority;
//  - long-latency LSU/MUL results, buffered in a FIFO.
//  Drops writes to XZR (X31). Prevents FIFO starvation by briefly stalling the ALU.
// PARAMETERS
//  FIFO_DEPTH   4   LSU result FIFO entries (power of 2, >=2)
//  STARVE_MAX   8   consecutive ALU-won cycles with FIFO non-empty before ALU stall
// PORTS
//  CLK        in   1   clock, rising edge
//  RST_N      in   1   reset, asynchronous, active-low
//  ALU_VALID  in   1   ALU result present this cycle (no backpressure except ALU_STALL)
//  ALU_RD     in   5   ALU destination register
//  ALU_DATA   in   64  ALU result
//  ALU_STALL  out  1   registered; ALU must hold its result, ALU inputs ignored
//  LSU_VALID  in   1   LSU result offered
//  LSU_READY  out  1   registered; FIFO can accept (push = LSU_VALID & LSU_READY)
//  LSU_RD     in   5   LSU destination register
//  LSU_DATA   in   64  LSU result
//  REG_WRITE  out  1   registered write enable to register file
//  WR_REG     out  5   registered write address
//  WR_DATA    out  64  registered write data
// BEHAVIOUR
//  - Reset (async): REG_WRITE=0, WR_REG=0, WR_DATA=0, ALU_STALL=0,
//    LSU_READY=1, FIFO empty, starve counter=0.
//  - Arbitration per cycle:
//    - ALU_VALID & !ALU_STALL -> ALU wins;
//    - else FIFO non-empty -> pop head;
//    - else idle.
//  - Winner appears on WR_* at next rising edge (1-cycle latency).
//  - REG_WRITE=1 only if the winner's rd != 31. An rd==31 entry still consumes
//    its slot/pop; WR_REG/WR_DATA still update to it.
//  - Idle cycle: REG_WRITE=0, WR_REG/WR_DATA hold previous values.
//  - FIFO: push and pop in the same cycle are legal; count unchanged.
//    - A pushed entry is poppable no earlier than the next cycle.
//    - Empty-to-write latency is 2 cycles.
//    - LSU_READY = (next count < FIFO_DEPTH), registered. It never rises
//      combinationally, so a pop while full frees the slot for the next cycle.
//    - Pointers wrap modulo FIFO_DEPTH.
//  - Starvation counter:
//    - Increments on each cycle where the ALU wins and the FIFO is non-empty.
//    - Clears when the FIFO pops or becomes empty.
//    - On reaching STARVE_MAX, ALU_STALL=1 for exactly one cycle. That cycle
//      pops the FIFO, then the counter clears and ALU_STALL returns to 0.
//  - ALU_VALID during ALU_STALL: result ignored; ALU re-presents it next cycle.
//  - Reset mid-operation: FIFO contents discarded, no write issued.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//  - Adds inputs RD_REG1/RD_REG2 (5) and RF_DATA1/RF_DATA2 (64).
//  - Adds outputs FWD_DATA1/FWD_DATA2 (64), combinational.
//  - FWD_DATAn = WR_DATA when REG_WRITE & WR_REG==RD_REGn & RD_REGn!=31;
//    otherwise RF_DATAn.
//  - Gives same-cycle write-to-read forwarding around the register file.
//  WB_BYPASS_EN undefined: those ports do not exist; no forwarding logic.
// TESTING
//  - Reset, then idle 5 cycles -> REG_WRITE=0 always, LSU_READY=1, ALU_STALL=0.
//  - ALU_VALID rd=3 data=0xDEAD at cycle n -> cycle n+1: REG_WRITE=1, WR_REG=3,
//    WR_DATA=0xDEAD.
//  - Same cycle: ALU rd=1 =0x11 and LSU rd=2 =0x22 pushed ->
//    n+1 writes X1=0x11, n+2 writes X2=0x22.
//  - 5 LSU pushes while ALU_VALID held high (depth 4) -> LSU_READY=0 after 4th.
//    After 8 ALU writes, ALU_STALL=1 for one cycle and the first LSU entry is written.
//  - ALU rd=31 data=0x55 -> REG_WRITE=0 next cycle; LSU rd=31 is popped, never written.
//  - WB_BYPASS_EN: REG_WRITE=1 WR_REG=5 WR_DATA=0x77, RD_REG1=5 RF_DATA1=0 ->
//    FWD_DATA1=0x77; RD_REG2=31 -> FWD_DATA2=RF_DATA2.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter merging ALU and buffered LSU results onto one register-file write port
//
// Purpose:
//   Sits directly in front of the 32x64 register file. Single-cycle ALU results
//   take priority; long-latency LSU/MUL results are buffered in a small FIFO and
//   drained when the ALU is idle. If the ALU keeps winning while the FIFO holds
//   data, the ALU is stalled for one cycle so the FIFO head can drain. Writes to
//   X31 (XZR) still consume their slot but never assert REG_WRITE.
//
// Parameters:
//   FIFO_DEPTH  LSU result FIFO entries (power of 2, >= 2)
//   STARVE_MAX  consecutive ALU-won cycles with a non-empty FIFO before an ALU stall
//
// Ports:
//   CLK        in   1   clock, rising edge
//   RST_N      in   1   asynchronous active-low reset
//   ALU_VALID  in   1   ALU result present this cycle
//   ALU_RD     in   5   ALU destination register
//   ALU_DATA   in   64  ALU result
//   ALU_STALL  out  1   registered; ALU holds its result, ALU inputs ignored
//   LSU_VALID  in   1   LSU result offered
//   LSU_READY  out  1   registered; FIFO can accept (push = LSU_VALID & LSU_READY)
//   LSU_RD     in   5   LSU destination register
//   LSU_DATA   in   64  LSU result
//   REG_WRITE  out  1   registered register-file write enable
//   WR_REG     out  5   registered write address
//   WR_DATA    out  64  registered write data
//
// Optional feature, enabled by defining WB_BYPASS_EN:
//   RD_REG1/RD_REG2   in   5   register-file read addresses
//   RF_DATA1/RF_DATA2 in   64  register-file read data
//   FWD_DATA1/FWD_DATA2 out 64 combinational read data with same-cycle write forwarding

module wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ALU_VALID,
    input  logic [4:0]  ALU_RD,
    input  logic [63:0] ALU_DATA,
    output logic        ALU_STALL,
    input  logic        LSU_VALID,
    output logic        LSU_READY,
    input  logic [4:0]  LSU_RD,
    input  logic [63:0] LSU_DATA,
    output logic        REG_WRITE,
    output logic [4:0]  WR_REG,
    output logic [63:0] WR_DATA
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  RD_REG1,
    input  logic [4:0]  RD_REG2,
    input  logic [63:0] RF_DATA1,
    input  logic [63:0] RF_DATA2,
    output logic [63:0] FWD_DATA1,
    output logic [63:0] FWD_DATA2
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);
    localparam logic [4:0]    XZR      = 5'd31;

    // FIFO storage: {rd, data}
    logic [68:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;

    logic          alu_win;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [4:0]    head_rd;
    logic [63:0]   head_data;

    logic          reg_write_next;
    logic [4:0]    wr_reg_next;
    logic [63:0]   wr_data_next;
    logic [CW-1:0] count_next;
    logic [SW-1:0] starve_next;
    logic          stall_next;
    logic          ready_next;

    // Pop only looks at the registered count, so an entry pushed this cycle
    // cannot be popped before the next one.
    assign fifo_empty = (count == '0);
    assign alu_win    = ALU_VALID & ~ALU_STALL;
    assign pop        = ~alu_win & ~fifo_empty;
    assign push       = LSU_VALID & LSU_READY;
    assign head_rd    = mem[rd_ptr][68:64];
    assign head_data  = mem[rd_ptr][63:0];

    always_comb begin
        reg_write_next = 1'b0;
        wr_reg_next    = WR_REG;
        wr_data_next   = WR_DATA;
        if (alu_win) begin
            reg_write_next = (ALU_RD != XZR);
            wr_reg_next    = ALU_RD;
            wr_data_next   = ALU_DATA;
        end else if (pop) begin
            reg_write_next = (head_rd != XZR);
            wr_reg_next    = head_rd;
            wr_data_next   = head_data;
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
        // Registered from the next count, so a pop while full reopens the
        // FIFO one cycle later rather than combinationally.
        ready_next = (count_next < DEPTH_C);
    end

    // The counter only advances while the ALU is beating a non-empty FIFO.
    // The stall cycle it triggers always pops (the ALU cannot win then), which
    // clears the counter and drops the stall again.
    always_comb begin
        starve_next = starve;
        if (pop || fifo_empty) begin
            starve_next = '0;
        end else if (alu_win && (starve != STARVE_C)) begin
            starve_next = starve + SW'(1);
        end
        stall_next = (starve_next == STARVE_C);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            REG_WRITE <= 1'b0;
            WR_REG    <= '0;
            WR_DATA   <= '0;
            ALU_STALL <= 1'b0;
            LSU_READY <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            starve    <= '0;
        end else begin
            REG_WRITE <= reg_write_next;
            WR_REG    <= wr_reg_next;
            WR_DATA   <= wr_data_next;
            ALU_STALL <= stall_next;
            LSU_READY <= ready_next;
            count     <= count_next;
            starve    <= starve_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {LSU_RD, LSU_DATA};
        end
    end

`ifdef WB_BYPASS_EN
    // Same-cycle write-to-read forwarding around the register file; X31 reads
    // always come from the file (hard zero).
    always_comb begin
        FWD_DATA1 = RF_DATA1;
        FWD_DATA2 = RF_DATA2;
        if (REG_WRITE && (WR_REG == RD_REG1) && (RD_REG1 != XZR)) begin
            FWD_DATA1 = WR_DATA;
        end
        if (REG_WRITE && (WR_REG == RD_REG2) && (RD_REG2 != XZR)) begin
            FWD_DATA2 = WR_DATA;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter

module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic        CLK;
    logic        RST_N;
    logic        ALU_VALID;
    logic [4:0]  ALU_RD;
    logic [63:0] ALU_DATA;
    logic        ALU_STALL;
    logic        LSU_VALID;
    logic        LSU_READY;
    logic [4:0]  LSU_RD;
    logic [63:0] LSU_DATA;
    logic        REG_WRITE;
    logic [4:0]  WR_REG;
    logic [63:0] WR_DATA;
`ifdef WB_BYPASS_EN
    logic [4:0]  RD_REG1;
    logic [4:0]  RD_REG2;
    logic [63:0] RF_DATA1;
    logic [63:0] RF_DATA2;
    logic [63:0] FWD_DATA1;
    logic [63:0] FWD_DATA2;
`endif

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ALU_VALID (ALU_VALID),
        .ALU_RD    (ALU_RD),
        .ALU_DATA  (ALU_DATA),
        .ALU_STALL (ALU_STALL),
        .LSU_VALID (LSU_VALID),
        .LSU_READY (LSU_READY),
        .LSU_RD    (LSU_RD),
        .LSU_DATA  (LSU_DATA),
        .REG_WRITE (REG_WRITE),
        .WR_REG    (WR_REG),
        .WR_DATA   (WR_DATA)
`ifdef WB_BYPASS_EN
        ,
        .RD_REG1   (RD_REG1),
        .RD_REG2   (RD_REG2),
        .RF_DATA1  (RF_DATA1),
        .RF_DATA2  (RF_DATA2),
        .FWD_DATA1 (FWD_DATA1),
        .FWD_DATA2 (FWD_DATA2)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
        ALU_VALID = av;
        ALU_RD    = ard;
        ALU_DATA  = ad;
        LSU_VALID = lv;
        LSU_RD    = lrd;
        LSU_DATA  = ld;
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] wreg,
                             input logic [63:0] wdata, input logic rdy, input logic stl);
        check({tag, ".REG_WRITE"}, 64'(REG_WRITE), 64'(we));
        check({tag, ".WR_REG"},    64'(WR_REG),    64'(wreg));
        check({tag, ".WR_DATA"},   WR_DATA,        wdata);
        check({tag, ".LSU_READY"}, 64'(LSU_READY), 64'(rdy));
        check({tag, ".ALU_STALL"}, 64'(ALU_STALL), 64'(stl));
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Reference model: queue of pending LSU results plus the arbitration rules.
    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } entry_t;

    entry_t      mq[$];
    logic        m_we;
    logic [4:0]  m_reg;
    logic [63:0] m_data;
    logic        m_stall;
    logic        m_ready;
    int          m_starve;

    task automatic model_reset();
        mq.delete();
        m_we     = 1'b0;
        m_reg    = '0;
        m_data   = '0;
        m_stall  = 1'b0;
        m_ready  = 1'b1;
        m_starve = 0;
    endtask

    task automatic model_step(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
        bit     was_empty;
        bit     popped;
        bit     alu_won;
        bit     pushed;
        entry_t e;
        was_empty = (mq.size() == 0);
        popped    = 1'b0;
        alu_won   = av && !m_stall;
        pushed    = lv && m_ready;
        if (alu_won) begin
            m_we   = (ard != 5'd31);
            m_reg  = ard;
            m_data = ad;
        end else if (!was_empty) begin
            e      = mq.pop_front();
            popped = 1'b1;
            m_we   = (e.rd != 5'd31);
            m_reg  = e.rd;
            m_data = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (pushed) mq.push_back({lrd, ld});
        if (popped || was_empty) m_starve = 0;
        else if (alu_won)        m_starve = m_starve + 1;
        m_stall = (m_starve == SMAX);
        m_ready = (mq.size() < DEPTH);
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [63:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ld;
        logic        we;
        logic [4:0]  wreg;
        logic [63:0] wdata;
        logic        rdy;
        logic        stl;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef WB_BYPASS_EN
        RD_REG1  = 0;
        RD_REG2  = 0;
        RF_DATA1 = 0;
        RF_DATA2 = 0;
`endif
        //          av ard  ad         lv lrd ld         we wreg wdata      rdy stl
        tbl[0]  = '{0, 0,  64'h0,     0, 0,  64'h0,     0, 0,  64'h0,     1, 0};
        tbl[1]  = '{1, 3,  64'hDEAD,  0, 0,  64'h0,     1, 3,  64'hDEAD,  1, 0};
        tbl[2]  = '{1, 1,  64'h11,    1, 2,  64'h22,    1, 1,  64'h11,    1, 0};
        tbl[3]  = '{0, 0,  64'h0,     0, 0,  64'h0,     1, 2,  64'h22,    1, 0};
        tbl[4]  = '{0, 0,  64'h0,     0, 0,  64'h0,     0, 2,  64'h22,    1, 0};
        tbl[5]  = '{1, 31, 64'h55,    0, 0,  64'h0,     0, 31, 64'h55,    1, 0};
        tbl[6]  = '{0, 0,  64'h0,     1, 31, 64'h66,    0, 31, 64'h55,    1, 0};
        tbl[7]  = '{0, 0,  64'h0,     0, 0,  64'h0,     0, 31, 64'h66,    1, 0};
        tbl[8]  = '{0, 0,  64'h0,     1, 7,  64'h77,    0, 31, 64'h66,    1, 0};
        tbl[9]  = '{1, 4,  64'h44,    1, 8,  64'h88,    1, 4,  64'h44,    1, 0};
        tbl[10] = '{0, 0,  64'h0,     0, 0,  64'h0,     1, 7,  64'h77,    1, 0};
        tbl[11] = '{0, 0,  64'h0,     0, 0,  64'h0,     1, 8,  64'h88,    1, 0};
        tbl[12] = '{0, 0,  64'h0,     0, 0,  64'h0,     0, 8,  64'h88,    1, 0};

        // Reset values, then 5 idle cycles.
        drive(0, 0, 0, 0, 0, 0);
        RST_N = 1'b0;
        @(negedge CLK);
        check_out("reset", 0, 0, 0, 1, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("idle%0d", i), 0, 0, 0, 1, 0);
        end

        // Directed vector table.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
            tick();
            check_out($sformatf("vec%0d", i), tbl[i].we, tbl[i].wreg, tbl[i].wdata, tbl[i].rdy, tbl[i].stl);
`ifdef WB_BYPASS_EN
            if (i == 1) begin
                RD_REG1  = 5'd3;
                RF_DATA1 = 64'h0;
                RD_REG2  = 5'd31;
                RF_DATA2 = 64'h1234;
                #1;
                check("fwd1_hit", FWD_DATA1, 64'hDEAD);
                check("fwd2_xzr", FWD_DATA2, 64'h1234);
                RD_REG1  = 5'd4;
                RF_DATA1 = 64'h9999;
                #1;
                check("fwd1_miss", FWD_DATA1, 64'h9999);
            end
`endif
        end

        // FIFO fill under constant ALU traffic, starvation stall, then drain.
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            drive(1, 5'(10 + (c % 8)), 64'hA000 + 64'(c), (c < 5), 5'(20 + c), 64'h100 + 64'(c));
            tick();
            if (c <= 8)
                check_out($sformatf("starve%0d", c), 1, 5'(10 + (c % 8)), 64'hA000 + 64'(c),
                          (c < 3), (c == 8));
            else if (c == 9)
                check_out("starve9", 1, 5'd20, 64'h100, 1, 0);
            else
                check_out("starve10", 1, 5'd12, 64'hA00A, 1, 0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            tick();
            if (k < 3) check_out($sformatf("drain%0d", k), 1, 5'(21 + k), 64'h101 + 64'(k), 1, 0);
            else       check_out("drain3", 0, 5'd23, 64'h103, 1, 0);
        end

        // Asynchronous reset mid-operation discards queued entries.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1, 5'd9, 64'hBB, 1, 5'd6, 64'hCC);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        #2 RST_N = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0, 1, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("post_rst%0d", k), 0, 0, 0, 1, 0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic        av;
            logic        lv;
            logic [4:0]  ard;
            logic [4:0]  lrd;
            logic [63:0] ad;
            logic [63:0] ld;
            int          pa;
            case (cyc / 200)
                0:       pa = 50;
                1:       pa = 92;
                2:       pa = 100;
                default: pa = 20;
            endcase
            av  = ($urandom_range(0, 99) < pa);
            lv  = ($urandom_range(0, 99) < 60);
            ard = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            lrd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            ad  = {32'($urandom), 32'($urandom)};
            ld  = {32'($urandom), 32'($urandom)};
            drive(av, ard, ad, lv, lrd, ld);
            model_step(av, ard, ad, lv, lrd, ld);
            tick();
            check_out($sformatf("rand%0d", cyc), m_we, m_reg, m_data, m_ready, m_stall);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
